sha2_block_engine: RTL and testbench
====================================

// Module: sha2_block_engine
// PURPOSE
//  Iterative SHA-2 compression engine, parametrised for 32-bit (SHA-224/256) and
//  64-bit (SHA-384/512) words. Runs one round per clock and chains multi-block
//  messages. Sits between the padding/block-formatter front end and the digest
//  register interface. K/IV tables come from the shared SHA-2 package, extended
//  with 64-bit entries.
// PARAMETERS
//  WORD_W   32  word width; legal values are 32 or 64 only (elaboration error otherwise)
//  ROUNDS   derived: 64 if WORD_W==32, 80 if WORD_W==64; not overridable
//  BLOCK_W  derived: 16*WORD_W message block width
// PORTS
//  clk         in   1           rising-edge clock
//  rst         in   1           synchronous, active-high reset
//  trunc       in   1           0: SHA-256/512 IV; 1: SHA-224/384 IV; sampled with first block
//  in_valid    in   1           block offered
//  in_ready    out  1           engine can accept a block
//  in_first    in   1           block starts a new message (reload IV)
//  in_last     in   1           block ends the message (publish digest)
//  in_block    in   BLOCK_W     big-endian block; word 0 in the MSBs
//  out_valid   out  1           digest valid
//  out_ready   in   1           digest consumer ready
//  out_digest  out  8*WORD_W    H0 in the MSBs; in trunc mode the unused low words are 0
//  busy        out  1           high in every state except IDLE
// BEHAVIOUR
//  - Reset: state=IDLE, in_ready=0 in the reset cycle then 1, out_valid=0,
//    out_digest=0, busy=0, round counter=0, H registers=0.
//  - FSM states: IDLE, ROUND, FINAL, HOLD.
//    IDLE : in_ready=1. When in_valid&&in_ready: latch the block into the 16-word
//           schedule shift register. Load a..h from IV (if in_first) or from H.
//           If in_first, also load H from IV and latch trunc. Latch in_last. Go to ROUND with t=0.
//    ROUND: one round per cycle using W[t], K[t]. For t>=16, compute the schedule
//           on the fly: W=s1(W[t-2])+W[t-7]+s0(W[t-15])+W[t-16].
//           At t==ROUNDS-1, go to FINAL.
//    FINAL: H[i] <= H[i] + working var (mod 2^WORD_W). Then go to HOLD if the
//           block was last, else IDLE.
//    HOLD : out_valid=1 and out_digest stable. On out_ready, go to IDLE and set
//           out_valid=0.
//  - Latency: accept edge to out_valid = ROUNDS+2 cycles (66 for 32-bit, 82 for 64-bit).
//    Back-to-back non-last blocks: in_ready is reasserted in the cycle after FINAL.
//  - in_ready=0 in ROUND/FINAL/HOLD. In HOLD, blocks are not accepted until the
//    digest is taken, even if out_ready is asserted in the same cycle.
//  - Sigma functions: 32-bit uses rotr 2/13/22, 6/11/25, s0 7/18/shr3, s1 17/19/shr10.
//    64-bit uses 28/34/39, 14/18/41, s0 1/8/shr7, s1 19/61/shr6.
//    Rotates are modulo WORD_W. All additions wrap at WORD_W.
//  - in_first=0 on the first block after reset: chain from H=0. This is legal and
//    not flagged.
//  - in_first=1 && in_last=1: single-block message.
//  - rst mid-ROUND or mid-HOLD: everything returns to its reset value next cycle.
//    The partial digest is discarded and no out_valid pulse occurs.
//  - trunc changing while not on a first block: ignored.
//  - Digest in trunc mode: 32-bit outputs H0..H6 with the low 32 bits = 0.
//    64-bit outputs H0..H5 with the low 128 bits = 0.
// TESTING
//  1. WORD_W=32, trunc=0, single-block padded "abc" -> after 66 cycles
//     out_digest=ba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad.
//  2. WORD_W=32, trunc=1, padded "abc" -> digest
//     23097d223405d8228642a477bda255b32aadbce4bda0b3f7e36c9da7, low 32 bits = 0.
//  3. WORD_W=32, 2-block "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq":
//     the first block has out_valid=0 throughout; the final digest is
//     248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1.
//  4. WORD_W=64, trunc=0, padded "abc" -> after 82 cycles the digest starts
//     ddaf35a193617abacc417349ae204131 and ends a54ca49f.
//  5. Hold out_ready=0 for 10 cycles in HOLD -> out_valid and digest stay stable,
//     in_ready=0, and an offered block is not accepted. Then set out_ready=1 ->
//     IDLE next cycle.
//  6. Assert rst at round 30 of test 1, then rerun test 1 -> no spurious out_valid,
//     and the correct digest is produced.

Source files
------------

// File: rtl/sha2_block_engine.sv
// Iterative SHA-2 compression engine (SHA-224/256 with WORD_W=32, SHA-384/512 with WORD_W=64).
// One round per clock; chains blocks of a message through the H registers.
module sha2_block_engine #(
  parameter int WORD_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  trunc,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_first,
  input  logic                  in_last,
  input  logic [16*WORD_W-1:0]  in_block,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [8*WORD_W-1:0]   out_digest,
  output logic                  busy
);

  localparam int ROUNDS  = (WORD_W == 64) ? 80 : 64;
  localparam int TRUNC_W = (WORD_W == 64) ? 2 : 1;
  localparam bit W64     = (WORD_W == 64);

  if (WORD_W != 32 && WORD_W != 64) begin : g_bad_word_w
    $error("sha2_block_engine: WORD_W must be 32 or 64");
  end

  localparam int S0A = W64 ? 28 : 2,  S0B = W64 ? 34 : 13, S0C = W64 ? 39 : 22;
  localparam int S1A = W64 ? 14 : 6,  S1B = W64 ? 18 : 11, S1C = W64 ? 41 : 25;
  localparam int M0A = W64 ? 1  : 7,  M0B = W64 ? 8  : 18, M0C = W64 ? 7  : 3;
  localparam int M1A = W64 ? 19 : 17, M1B = W64 ? 61 : 19, M1C = W64 ? 6  : 10;

  // SHA-256 constants are the upper halves of the SHA-512 ones; SHA-224 IV is the lower half of SHA-384 IV.
  localparam logic [63:0] K64 [80] = '{
    64'h428a2f98d728ae22, 64'h7137449123ef65cd, 64'hb5c0fbcfec4d3b2f, 64'he9b5dba58189dbbc,
    64'h3956c25bf348b538, 64'h59f111f1b605d019, 64'h923f82a4af194f9b, 64'hab1c5ed5da6d8118,
    64'hd807aa98a3030242, 64'h12835b0145706fbe, 64'h243185be4ee4b28c, 64'h550c7dc3d5ffb4e2,
    64'h72be5d74f27b896f, 64'h80deb1fe3b1696b1, 64'h9bdc06a725c71235, 64'hc19bf174cf692694,
    64'he49b69c19ef14ad2, 64'hefbe4786384f25e3, 64'h0fc19dc68b8cd5b5, 64'h240ca1cc77ac9c65,
    64'h2de92c6f592b0275, 64'h4a7484aa6ea6e483, 64'h5cb0a9dcbd41fbd4, 64'h76f988da831153b5,
    64'h983e5152ee66dfab, 64'ha831c66d2db43210, 64'hb00327c898fb213f, 64'hbf597fc7beef0ee4,
    64'hc6e00bf33da88fc2, 64'hd5a79147930aa725, 64'h06ca6351e003826f, 64'h142929670a0e6e70,
    64'h27b70a8546d22ffc, 64'h2e1b21385c26c926, 64'h4d2c6dfc5ac42aed, 64'h53380d139d95b3df,
    64'h650a73548baf63de, 64'h766a0abb3c77b2a8, 64'h81c2c92e47edaee6, 64'h92722c851482353b,
    64'ha2bfe8a14cf10364, 64'ha81a664bbc423001, 64'hc24b8b70d0f89791, 64'hc76c51a30654be30,
    64'hd192e819d6ef5218, 64'hd69906245565a910, 64'hf40e35855771202a, 64'h106aa07032bbd1b8,
    64'h19a4c116b8d2d0c8, 64'h1e376c085141ab53, 64'h2748774cdf8eeb99, 64'h34b0bcb5e19b48a8,
    64'h391c0cb3c5c95a63, 64'h4ed8aa4ae3418acb, 64'h5b9cca4f7763e373, 64'h682e6ff3d6b2b8a3,
    64'h748f82ee5defb2fc, 64'h78a5636f43172f60, 64'h84c87814a1f0ab72, 64'h8cc702081a6439ec,
    64'h90befffa23631e28, 64'ha4506cebde82bde9, 64'hbef9a3f7b2c67915, 64'hc67178f2e372532b,
    64'hca273eceea26619c, 64'hd186b8c721c0c207, 64'heada7dd6cde0eb1e, 64'hf57d4f7fee6ed178,
    64'h06f067aa72176fba, 64'h0a637dc5a2c898a6, 64'h113f9804bef90dae, 64'h1b710b35131c471b,
    64'h28db77f523047d84, 64'h32caab7b40c72493, 64'h3c9ebe0a15c9bebc, 64'h431d67c49c100d4c,
    64'h4cc5d4becb3e42b6, 64'h597f299cfc657e2a, 64'h5fcb6fab3ad6faec, 64'h6c44198c4a475817
  };
  localparam logic [63:0] IV512 [8] = '{
    64'h6a09e667f3bcc908, 64'hbb67ae8584caa73b, 64'h3c6ef372fe94f82b, 64'ha54ff53a5f1d36f1,
    64'h510e527fade682d1, 64'h9b05688c2b3e6c1f, 64'h1f83d9abfb41bd6b, 64'h5be0cd19137e2179
  };
  localparam logic [63:0] IV384 [8] = '{
    64'hcbbb9d5dc1059ed8, 64'h629a292a367cd507, 64'h9159015a3070dd17, 64'h152fecd8f70e5939,
    64'h67332667ffc00b31, 64'h8eb44a8768581511, 64'hdb0c2e0d64f98fa7, 64'h47b5481dbefa4fa4
  };

  function automatic logic [WORD_W-1:0] rotr(input logic [WORD_W-1:0] x, input int n);
    return (x >> n) | (x << (WORD_W - n));
  endfunction
  function automatic logic [WORD_W-1:0] big0(input logic [WORD_W-1:0] x);
    return rotr(x, S0A) ^ rotr(x, S0B) ^ rotr(x, S0C);
  endfunction
  function automatic logic [WORD_W-1:0] big1(input logic [WORD_W-1:0] x);
    return rotr(x, S1A) ^ rotr(x, S1B) ^ rotr(x, S1C);
  endfunction
  function automatic logic [WORD_W-1:0] sml0(input logic [WORD_W-1:0] x);
    return rotr(x, M0A) ^ rotr(x, M0B) ^ (x >> M0C);
  endfunction
  function automatic logic [WORD_W-1:0] sml1(input logic [WORD_W-1:0] x);
    return rotr(x, M1A) ^ rotr(x, M1B) ^ (x >> M1C);
  endfunction
  function automatic logic [WORD_W-1:0] k_word(input logic [6:0] t);
    return WORD_W'(K64[t] >> (64 - WORD_W));
  endfunction
  function automatic logic [WORD_W-1:0] iv_word(input int i, input logic tr);
    return WORD_W'((tr ? IV384[i] : IV512[i]) >> ((!W64 && !tr) ? 32 : 0));
  endfunction

  typedef enum logic [1:0] {S_IDLE, S_ROUND, S_FINAL, S_HOLD} state_t;

  state_t            state_q, state_d;
  logic [6:0]        t_q, t_d;
  logic              trunc_q, trunc_d;
  logic              last_q, last_d;
  logic [WORD_W-1:0] h_q [8], h_d [8];
  logic [WORD_W-1:0] wv_q [8], wv_d [8];
  logic [WORD_W-1:0] w_q [16], w_d [16];
  logic [WORD_W-1:0] t1, t2, w_next;

  assign in_ready  = (state_q == S_IDLE) && !rst;
  assign out_valid = (state_q == S_HOLD);
  assign busy      = (state_q != S_IDLE);

  always_comb begin
    t1 = wv_q[7] + big1(wv_q[4]) + ((wv_q[4] & wv_q[5]) ^ (~wv_q[4] & wv_q[6]))
         + k_word(t_q) + w_q[0];
    t2 = big0(wv_q[0]) + ((wv_q[0] & wv_q[1]) ^ (wv_q[0] & wv_q[2]) ^ (wv_q[1] & wv_q[2]));
    // The window holds W[t..t+15], so W[t+16] is formed one step ahead of its use.
    w_next = sml1(w_q[14]) + w_q[9] + sml0(w_q[1]) + w_q[0];
  end

  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    trunc_d = trunc_q;
    last_d  = last_q;
    h_d     = h_q;
    wv_d    = wv_q;
    w_d     = w_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready) begin
          for (int i = 0; i < 16; i++) w_d[i] = in_block[(16-i)*WORD_W-1 -: WORD_W];
          for (int i = 0; i < 8; i++) begin
            wv_d[i] = in_first ? iv_word(i, trunc) : h_q[i];
            if (in_first) h_d[i] = iv_word(i, trunc);
          end
          if (in_first) trunc_d = trunc;
          last_d  = in_last;
          t_d     = '0;
          state_d = S_ROUND;
        end
      end
      S_ROUND: begin
        wv_d[0] = t1 + t2;
        wv_d[1] = wv_q[0];
        wv_d[2] = wv_q[1];
        wv_d[3] = wv_q[2];
        wv_d[4] = wv_q[3] + t1;
        wv_d[5] = wv_q[4];
        wv_d[6] = wv_q[5];
        wv_d[7] = wv_q[6];
        for (int i = 0; i < 15; i++) w_d[i] = w_q[i+1];
        w_d[15] = w_next;
        t_d     = t_q + 7'd1;
        if (t_q == 7'(ROUNDS - 1)) state_d = S_FINAL;
      end
      S_FINAL: begin
        for (int i = 0; i < 8; i++) h_d[i] = h_q[i] + wv_q[i];
        state_d = last_q ? S_HOLD : S_IDLE;
      end
      default: begin
        if (out_ready) state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    out_digest = '0;
    for (int i = 0; i < 8; i++) out_digest[(8-i)*WORD_W-1 -: WORD_W] = h_q[i];
    if (trunc_q) out_digest[TRUNC_W*WORD_W-1:0] = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      t_q     <= '0;
      trunc_q <= 1'b0;
      last_q  <= 1'b0;
      for (int i = 0; i < 8; i++) h_q[i] <= '0;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      trunc_q <= trunc_d;
      last_q  <= last_d;
      h_q     <= h_d;
    end
  end

  always_ff @(posedge clk) begin
    wv_q <= wv_d;
    w_q  <= w_d;
  end

endmodule

// File: tb/tb_sha2_block_engine.sv
// Bench for sha2_block_engine: 32-bit and 64-bit instances checked against known SHA-2 digests
// through a queue of expected results.
module tb_sha2_block_engine;

  localparam logic [511:0] BLK_ABC32 = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [511:0] BLK_2B1 = {
    32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
    32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
    32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
    32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
  localparam logic [511:0]  BLK_2B2   = {448'h0, 64'h00000000000001c0};
  localparam logic [1023:0] BLK_ABC64 = {64'h6162638000000000, 896'h0, 64'h18};
  localparam logic [255:0] EXP256_ABC =
    256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] EXP224_ABC =
    {224'h23097d223405d8228642a477bda255b32aadbce4bda0b3f7e36c9da7, 32'h0};
  localparam logic [255:0] EXP256_2B =
    256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
  localparam logic [159:0] EXP512_ABC_ENDS = {128'hddaf35a193617abacc417349ae204131, 32'ha54ca49f};

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic tr32, iv32, ir32, if32, il32, ov32, ordy32, busy32;
  logic [511:0] blk32;
  logic [255:0] dig32;
  logic tr64, iv64, ir64, if64, il64, ov64, ordy64, busy64;
  logic [1023:0] blk64;
  logic [511:0] dig64;

  int checks = 0;
  int errors = 0;
  logic [255:0] exp32_q[$];
  logic [159:0] exp64_q[$];

  sha2_block_engine #(.WORD_W(32)) dut32 (
    .clk(clk), .rst(rst), .trunc(tr32), .in_valid(iv32), .in_ready(ir32),
    .in_first(if32), .in_last(il32), .in_block(blk32), .out_valid(ov32),
    .out_ready(ordy32), .out_digest(dig32), .busy(busy32));

  sha2_block_engine #(.WORD_W(64)) dut64 (
    .clk(clk), .rst(rst), .trunc(tr64), .in_valid(iv64), .in_ready(ir64),
    .in_first(if64), .in_last(il64), .in_block(blk64), .out_valid(ov64),
    .out_ready(ordy64), .out_digest(dig64), .busy(busy64));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Returns one cycle after the accept edge (cycle 1, the accept cycle being cycle 0).
  task automatic send32(input logic [511:0] blk, input logic first, input logic last, input logic tr);
    int n = 0;
    blk32 = blk; if32 = first; il32 = last; tr32 = tr; iv32 = 1'b1;
    while (ir32 !== 1'b1 && n < 300) begin tick(); n++; end
    checks++;
    if (ir32 !== 1'b1) begin
      errors++;
      $display("FAIL send32_ready: in_ready=%b after %0d cycles, required 1", ir32, n);
    end
    tick();
    iv32 = 1'b0; if32 = 1'b0; il32 = 1'b0;
  endtask

  task automatic wait_dig32(output int cyc);
    cyc = 1;
    while (ov32 !== 1'b1 && cyc < 300) begin tick(); cyc++; end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++; if (ir32 !== 1'b0) begin errors++; $display("FAIL reset_in_ready32: got %b required 0", ir32); end
    checks++; if (ov32 !== 1'b0) begin errors++; $display("FAIL reset_out_valid32: got %b required 0", ov32); end
    checks++; if (busy32 !== 1'b0) begin errors++; $display("FAIL reset_busy32: got %b required 0", busy32); end
    checks++; if (dig32 !== '0) begin errors++; $display("FAIL reset_digest32: got %h required 0", dig32); end
    checks++; if (ir64 !== 1'b0) begin errors++; $display("FAIL reset_in_ready64: got %b required 0", ir64); end
    checks++; if (ov64 !== 1'b0) begin errors++; $display("FAIL reset_out_valid64: got %b required 0", ov64); end
    checks++; if (dig64 !== '0) begin errors++; $display("FAIL reset_digest64: got %h required 0", dig64); end
    rst = 1'b0;
    tick();
    checks++; if (ir32 !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready32: got %b required 1", ir32); end
    checks++; if (ir64 !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready64: got %b required 1", ir64); end
  endtask

  task automatic test_sha256_abc(input string name);
    int cyc;
    logic [255:0] e;
    exp32_q.push_back(EXP256_ABC);
    send32(BLK_ABC32, 1'b1, 1'b1, 1'b0);
    wait_dig32(cyc);
    checks++; if (ov32 !== 1'b1) begin errors++; $display("FAIL %s_out_valid: got %b required 1", name, ov32); end
    checks++; if (cyc != 66) begin errors++; $display("FAIL %s_latency: got %0d required 66", name, cyc); end
    checks++; if (busy32 !== 1'b1) begin errors++; $display("FAIL %s_busy_hold: got %b required 1", name, busy32); end
    e = exp32_q.pop_front();
    checks++; if (dig32 !== e) begin errors++; $display("FAIL %s_digest: got %h required %h", name, dig32, e); end
    tick();
    checks++; if (ov32 !== 1'b0) begin errors++; $display("FAIL %s_release: out_valid=%b required 0", name, ov32); end
  endtask

  task automatic test_sha224_abc();
    int cyc;
    logic [255:0] e;
    exp32_q.push_back(EXP224_ABC);
    send32(BLK_ABC32, 1'b1, 1'b1, 1'b1);
    wait_dig32(cyc);
    e = exp32_q.pop_front();
    checks++; if (dig32 !== e) begin errors++; $display("FAIL sha224_digest: got %h required %h", dig32, e); end
    checks++; if (dig32[31:0] !== 32'h0) begin errors++; $display("FAIL sha224_low_word: got %h required 0", dig32[31:0]); end
    tick();
  endtask

  task automatic test_back_to_back();
    int n;
    int cyc;
    logic seen;
    logic [255:0] e;
    exp32_q.push_back(EXP256_2B);
    send32(BLK_2B1, 1'b1, 1'b0, 1'b0);
    n = 1;
    seen = 1'b0;
    while (ir32 !== 1'b1 && n < 300) begin
      if (ov32 === 1'b1) seen = 1'b1;
      tick();
      n++;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL b2b_first_block_out_valid: got 1 required 0"); end
    checks++; if (n != 66) begin errors++; $display("FAIL b2b_in_ready_cycle: got %0d required 66", n); end
    // trunc on a non-first block must not alter the digest format
    send32(BLK_2B2, 1'b0, 1'b1, 1'b1);
    wait_dig32(cyc);
    e = exp32_q.pop_front();
    checks++; if (dig32 !== e) begin errors++; $display("FAIL b2b_digest: got %h required %h", dig32, e); end
    tick();
  endtask

  task automatic test_sha512_abc();
    int n = 0;
    int cyc;
    logic [159:0] e;
    exp64_q.push_back(EXP512_ABC_ENDS);
    blk64 = BLK_ABC64; if64 = 1'b1; il64 = 1'b1; tr64 = 1'b0; iv64 = 1'b1;
    while (ir64 !== 1'b1 && n < 300) begin tick(); n++; end
    checks++; if (ir64 !== 1'b1) begin errors++; $display("FAIL sha512_ready: got %b required 1", ir64); end
    tick();
    iv64 = 1'b0; if64 = 1'b0; il64 = 1'b0;
    cyc = 1;
    while (ov64 !== 1'b1 && cyc < 300) begin tick(); cyc++; end
    checks++; if (cyc != 82) begin errors++; $display("FAIL sha512_latency: got %0d required 82", cyc); end
    e = exp64_q.pop_front();
    checks++;
    if ({dig64[511:384], dig64[31:0]} !== e) begin
      errors++;
      $display("FAIL sha512_digest_ends: got %h required %h", {dig64[511:384], dig64[31:0]}, e);
    end
    tick();
  endtask

  task automatic test_hold_backpressure();
    int cyc;
    logic [255:0] e;
    exp32_q.push_back(EXP256_ABC);
    ordy32 = 1'b0;
    send32(BLK_ABC32, 1'b1, 1'b1, 1'b0);
    wait_dig32(cyc);
    e = exp32_q.pop_front();
    checks++; if (dig32 !== e) begin errors++; $display("FAIL hold_digest: got %h required %h", dig32, e); end
    blk32 = BLK_2B1; if32 = 1'b1; il32 = 1'b1; iv32 = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (ov32 !== 1'b1 || dig32 !== e || ir32 !== 1'b0) begin
        errors++;
        $display("FAIL hold_stable[%0d]: out_valid=%b in_ready=%b digest=%h required 1/0/%h",
                 i, ov32, ir32, dig32, e);
      end
    end
    ordy32 = 1'b1;
    tick();
    iv32 = 1'b0; if32 = 1'b0; il32 = 1'b0;
    checks++; if (ov32 !== 1'b0) begin errors++; $display("FAIL hold_release_out_valid: got %b required 0", ov32); end
    checks++; if (busy32 !== 1'b0) begin errors++; $display("FAIL hold_no_accept_busy: got %b required 0", busy32); end
    checks++; if (ir32 !== 1'b1) begin errors++; $display("FAIL hold_release_in_ready: got %b required 1", ir32); end
    tick();
  endtask

  task automatic test_reset_mid_round();
    int n;
    int spurious;
    send32(BLK_ABC32, 1'b1, 1'b1, 1'b0);
    n = 1;
    while (n < 31) begin tick(); n++; end
    rst = 1'b1;
    checks++; if (ir32 !== 1'b0) begin errors++; $display("FAIL rst_round_in_ready: got %b required 0", ir32); end
    tick();
    checks++; if (busy32 !== 1'b0) begin errors++; $display("FAIL rst_round_busy: got %b required 0", busy32); end
    checks++; if (dig32 !== '0) begin errors++; $display("FAIL rst_round_digest: got %h required 0", dig32); end
    rst = 1'b0;
    spurious = 0;
    for (int i = 0; i < 100; i++) begin
      if (ov32 !== 1'b0) spurious++;
      tick();
    end
    checks++; if (spurious != 0) begin errors++; $display("FAIL rst_round_spurious: got %0d out_valid cycles required 0", spurious); end
    test_sha256_abc("rerun");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    tr32 = 1'b0; iv32 = 1'b0; if32 = 1'b0; il32 = 1'b0; ordy32 = 1'b1; blk32 = '0;
    tr64 = 1'b0; iv64 = 1'b0; if64 = 1'b0; il64 = 1'b0; ordy64 = 1'b1; blk64 = '0;
    test_reset();
    test_sha256_abc("sha256_abc");
    test_sha224_abc();
    test_back_to_back();
    test_sha512_abc();
    test_hold_backpressure();
    test_reset_mid_round();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
